tdc_hist_ctrl: RTL and testbench
================================

# tdc_hist_ctrl

Code-density calibration controller for the TDC. It sits downstream of the delay-line encoder and runs one calibration pass per `start`. A pass clears an on-chip histogram, counts valid encoder codes into per-bin counters until a programmed number of hits has been collected, then hands the histogram to software through a read port. The resulting bin widths feed the TDC nonlinearity correction LUT.

## Interface
Parameters:
- `NUM_BINS`, 576: number of histogram bins; codes 1..NUM_BINS-1 are counted.
- `BIN_AW`, 10: bin address width; must satisfy 2**BIN_AW >= NUM_BINS.
- `CNT_WIDTH`, 16: per-bin counter width; counters saturate.
- `HITS_WIDTH`, 24: width of the hit-target and hit counters.

Ports:
- `clk`  in  1: single clock; all logic is on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle request to begin a pass; honoured only in IDLE.
- `num_hits`  in  HITS_WIDTH: hit target, sampled on the accepted `start`.
- `code_valid`  in  1: encoder output qualifier, one code per cycle.
- `code`  in  16: encoder output; 0 means no edge.
- `busy`  out  1: high from the cycle after an accepted `start` until `done`.
- `done`  out  1: one-cycle pulse at the end of a pass.
- `ovf`  out  1: sticky; set when any bin saturates during the current pass.
- `hits`  out  HITS_WIDTH: accepted-hit count of the current or last pass.
- `rd_en`  in  1: histogram read request.
- `rd_addr`  in  BIN_AW: bin to read.
- `rd_data`  out  CNT_WIDTH: bin contents.
- `rd_valid`  out  1: `rd_data` is valid.

## Operation
- The histogram is an internal RAM of NUM_BINS x CNT_WIDTH with synchronous read (1-cycle latency) and one write port.
- The FSM has states IDLE, CLEAR, ACQ, DRAIN and DONE.
  - IDLE: `start` latches `num_hits`, clears `hits` and `ovf`, and moves to CLEAR.
  - CLEAR: writes 0 to addresses 0..NUM_BINS-1, one per cycle (NUM_BINS cycles), then moves to ACQ. Codes arriving during CLEAR are dropped.
  - ACQ: when `hits == num_hits`, moves to DRAIN without accepting further codes. This check comes first, so `num_hits = 0` gives an all-zero histogram. Otherwise a code is accepted iff `code_valid` is high and 1 <= `code` <= NUM_BINS-1. Code 0 and out-of-range codes are dropped and not counted.
  - Each accepted code increments `hits` and starts a 2-stage read-modify-write:
    - stage A issues the RAM read of bin `code`;
    - stage B writes back min(value+1, 2**CNT_WIDTH-1).
  - If stage B writes back a saturated value, `ovf` is set.
  - Forwarding is required: when stage A reads the bin stage B is writing in the same cycle, stage A uses the stage-B result. Back-to-back identical codes must each count exactly once, with no lost increments for any code sequence.
  - DRAIN: 2 cycles, letting the pipeline empty; then DONE.
  - DONE: 1 cycle with `done` high, then IDLE.
- `start` outside IDLE is ignored.
- Read port:
  - Serviced only in IDLE. In IDLE, `rd_en` returns `rd_data` with `rd_valid` high on the next cycle.
  - `rd_addr >= NUM_BINS` returns 0 with `rd_valid` high.
  - `rd_en` outside IDLE is ignored: `rd_valid` stays 0 and `rd_data` holds its value.
- Histogram contents persist across passes until the next CLEAR.

## Timing
- Reset values: FSM in IDLE; `busy`, `done`, `ovf`, `rd_valid` = 0; `hits` = 0; `rd_data` = 0; pipeline stages invalid. RAM contents are not reset.
- A reset in any state aborts the pass immediately and returns to IDLE on the next cycle. Any pending write is discarded.
- `start` accepted at cycle T:
  - `busy` = 1 from T+1.
  - CLEAR occupies T+1..T+NUM_BINS; ACQ is first active at T+NUM_BINS+1.
- Last accepted code at cycle L:
  - its write completes at L+1;
  - DRAIN occupies the two cycles after the target is observed;
  - `done` = 1 and `busy` = 0 in the DONE cycle;
  - reads are legal from the following cycle.
- Minimum pass length with `num_hits = 0`: `done` at T+NUM_BINS+4.
- `hits` is registered: it updates the cycle after acceptance and saturates at 2**HITS_WIDTH-1.
- Throughput: one accepted code per cycle, sustained.

## Test plan
- NUM_BINS=576 and `num_hits`=0 after reset → `busy` high at T+1, `done` single pulse at T+580, all 576 bins read 0, `hits`=0, `ovf`=0.
- `num_hits`=10; codes 5,5,5,5 back-to-back, then 7,5,7,5,7,5 → bin5=7, bin7=3, all other bins 0, `hits`=10.
- `num_hits`=4 with codes 0, 600, 3 (`code_valid` low), 1, 575, 2, 2, 9 (valid) → bins 1/575/2 = 1/1/2, bin9=0, `hits`=4, and the code 9 after the target is ignored.
- CNT_WIDTH=4; `num_hits`=20 of code 12 back-to-back → bin12=15, `ovf`=1 and remains 1 until the next `start`.
- `start` pulsed again mid-ACQ, and `rd_en` issued during ACQ → pass unaffected, `rd_valid` stays 0. After `done`, `rd_addr`=1000 → `rd_data`=0 with `rd_valid`=1 one cycle later.
- `rst` asserted mid-ACQ → next cycle all outputs at reset values. A new `start` with `num_hits`=2 and codes 3,3 then yields bin3=2 and all other bins 0.

Source files
------------

// File: rtl/tdc_hist_ctrl.sv
// TDC code-density calibration: clears a per-bin histogram, accumulates encoder
// codes until a hit target is reached, then serves the bins through a read port.
module tdc_hist_ctrl #(
  parameter int NUM_BINS   = 576,
  parameter int BIN_AW     = 10,
  parameter int CNT_WIDTH  = 16,
  parameter int HITS_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [HITS_WIDTH-1:0] num_hits,
  input  logic                  code_valid,
  input  logic [15:0]           code,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [HITS_WIDTH-1:0] hits,
  input  logic                  rd_en,
  input  logic [BIN_AW-1:0]     rd_addr,
  output logic [CNT_WIDTH-1:0]  rd_data,
  output logic                  rd_valid
);

  // state    | meaning
  // ST_IDLE  | waiting for start; read port serviced
  // ST_CLEAR | zeroing one bin per cycle, top address down to 0
  // ST_ACQ   | accepting codes until hits reaches the target
  // ST_DRAIN | two cycles for the read-modify-write pipeline to empty
  // ST_DONE  | one-cycle done pulse
  typedef enum logic [2:0] {ST_IDLE, ST_CLEAR, ST_ACQ, ST_DRAIN, ST_DONE} state_t;

  localparam logic [15:0]       CODE_MAX = 16'(NUM_BINS - 1);
  localparam logic [BIN_AW-1:0] ADDR_MAX = BIN_AW'(NUM_BINS - 1);

  state_t state, state_next;
  logic [BIN_AW-1:0]     cnt;
  logic [HITS_WIDTH-1:0] target;

  logic [CNT_WIDTH-1:0] mem [NUM_BINS];
  logic [CNT_WIDTH-1:0] ram_q;
  logic                 mem_we, mem_re;
  logic [BIN_AW-1:0]    mem_wa, mem_ra;
  logic [CNT_WIDTH-1:0] mem_wd;

  logic                 a_vld, a_fwd;
  logic [BIN_AW-1:0]    a_addr;
  logic [CNT_WIDTH-1:0] wr_last, base, inc;

  logic              code_ok, at_target, accept, rd_req, rd_ok, rd_oor;
  logic [BIN_AW-1:0] code_idx;
  logic [CNT_WIDTH-1:0] rd_hold;

  assign code_ok   = code_valid && (code != 16'd0) && (code <= CODE_MAX);
  assign code_idx  = code[BIN_AW-1:0];
  assign at_target = (hits == target);
  assign accept    = (state == ST_ACQ) && !at_target && code_ok;
  assign rd_req    = (state == ST_IDLE) && rd_en;
  assign rd_ok     = (rd_addr <= ADDR_MAX);

  assign busy = (state == ST_CLEAR) || (state == ST_ACQ) || (state == ST_DRAIN);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_CLEAR;
      ST_CLEAR: if (cnt == '0) state_next = ST_ACQ;
      ST_ACQ:   if (at_target) state_next = ST_DRAIN;
      ST_DRAIN: if (cnt == '0) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Shared down-counter: CLEAR address, then preloaded to 1 for the two DRAIN cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      case (state)
        ST_IDLE:  if (start) cnt <= ADDR_MAX;
        ST_CLEAR: if (cnt != '0) cnt <= cnt - 1'b1;
        ST_ACQ:   cnt <= BIN_AW'(1);
        ST_DRAIN: if (cnt != '0) cnt <= cnt - 1'b1;
        default:  cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      target <= '0;
      hits   <= '0;
      ovf    <= 1'b0;
    end else if ((state == ST_IDLE) && start) begin
      target <= num_hits;
      hits   <= '0;
      ovf    <= 1'b0;
    end else begin
      if (accept && !(&hits)) hits <= hits + 1'b1;
      if (a_vld && (&inc))    ovf  <= 1'b1;
    end
  end

  // Stage B: the RAM read of a bin written in the same cycle returns the old
  // value, so a_fwd selects the previous write-back instead.
  assign base = a_fwd ? wr_last : ram_q;
  assign inc  = (&base) ? base : base + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_vld <= 1'b0;
      a_fwd <= 1'b0;
    end else begin
      a_vld <= accept;
      a_fwd <= accept && a_vld && (code_idx == a_addr);
    end
    if (accept) a_addr  <= code_idx;
    if (a_vld)  wr_last <= inc;
  end

  always_comb begin
    mem_we = 1'b0;
    mem_wa = a_addr;
    mem_wd = inc;
    if (!rst) begin
      if (state == ST_CLEAR) begin
        mem_we = 1'b1;
        mem_wa = cnt;
        mem_wd = '0;
      end else if (a_vld) begin
        mem_we = 1'b1;
      end
    end
  end

  always_comb begin
    mem_ra = rd_addr;
    if (state == ST_ACQ) mem_ra = code_idx;
    mem_re = accept || (rd_req && rd_ok);
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk) begin
    if (mem_re) ram_q <= mem[mem_ra];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_oor   <= 1'b0;
      rd_hold  <= '0;
    end else begin
      rd_valid <= rd_req;
      rd_oor   <= !rd_ok;
      rd_hold  <= rd_data;
    end
  end

  // ram_q is shared with the acquisition pipeline, so the last read result is held separately.
  always_comb begin
    rd_data = rd_hold;
    if (rd_valid) rd_data = rd_oor ? '0 : ram_q;
  end

endmodule

// File: tb/tb_tdc_hist_ctrl.sv
// Directed bench for tdc_hist_ctrl: a default-size instance and a 4-bit-counter
// instance for saturation, with hand-computed expected histograms.
module tb_tdc_hist_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [23:0] num_hits;
  logic        code_valid;
  logic [15:0] code;
  logic        busy, done, ovf, rd_valid;
  logic [23:0] hits;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [15:0] rd_data;

  logic        start4, code_valid4, rd_en4;
  logic [23:0] num_hits4;
  logic [15:0] code4;
  logic [3:0]  rd_addr4;
  logic        busy4, done4, ovf4, rd_valid4;
  logic [23:0] hits4;
  logic [3:0]  rd_data4;

  int checks = 0;
  int failures = 0;

  tdc_hist_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .num_hits(num_hits),
    .code_valid(code_valid), .code(code), .busy(busy), .done(done),
    .ovf(ovf), .hits(hits), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid)
  );

  tdc_hist_ctrl #(.NUM_BINS(16), .BIN_AW(4), .CNT_WIDTH(4), .HITS_WIDTH(24)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .num_hits(num_hits4),
    .code_valid(code_valid4), .code(code4), .busy(busy4), .done(done4),
    .ovf(ovf4), .hits(hits4), .rd_en(rd_en4), .rd_addr(rd_addr4),
    .rd_data(rd_data4), .rd_valid(rd_valid4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pass(input logic [23:0] nh);
    start = 1'b1;
    num_hits = nh;
    tick();
    start = 1'b0;
  endtask

  task automatic goto_acq();
    repeat (576) tick();
  endtask

  task automatic feed(input logic [15:0] c, input logic v);
    code = c;
    code_valid = v;
    tick();
    code = 16'd0;
    code_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    tick();
  endtask

  task automatic read_bin(input logic [9:0] a, output logic [15:0] d, output logic v);
    rd_en = 1'b1;
    rd_addr = a;
    tick();
    rd_en = 1'b0;
    d = rd_data;
    v = rd_valid;
  endtask

  // Counts bins (other than the skipped ones) that read non-zero or without rd_valid.
  task automatic scan_others(input int s0, input int s1, input int s2, output int bad);
    logic [15:0] d;
    logic v;
    bad = 0;
    for (int i = 0; i < 576; i++) begin
      if (i == s0 || i == s1 || i == s2) continue;
      read_bin(10'(i), d, v);
      if (v !== 1'b1 || d !== 16'd0) bad++;
    end
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    checks++; if (hits !== 24'd0) begin failures++; $display("FAIL reset_hits got=%0d exp=0", hits); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    checks++; if (rd_data !== 16'd0) begin failures++; $display("FAIL reset_rd_data got=%0d exp=0", rd_data); end
  endtask

  task automatic test_zero_hits();
    int dfirst, dcnt, busy_bad, bad;
    dfirst = -1; dcnt = 0; busy_bad = 0;
    start_pass(24'd0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL zero_busy_t1 got=%b exp=1", busy); end
    for (int c = 1; c <= 590; c++) begin
      if (done === 1'b1) begin
        dcnt++;
        if (dfirst < 0) dfirst = c;
      end
      if (busy !== (c < 580)) busy_bad++;
      tick();
    end
    checks++; if (dfirst !== 580) begin failures++; $display("FAIL zero_done_cycle got=%0d exp=580", dfirst); end
    checks++; if (dcnt !== 1) begin failures++; $display("FAIL zero_done_pulses got=%0d exp=1", dcnt); end
    checks++; if (busy_bad !== 0) begin failures++; $display("FAIL zero_busy_window bad_cycles=%0d exp=0", busy_bad); end
    checks++; if (hits !== 24'd0) begin failures++; $display("FAIL zero_hits got=%0d exp=0", hits); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL zero_ovf got=%b exp=0", ovf); end
    scan_others(-1, -1, -1, bad);
    checks++; if (bad !== 0) begin failures++; $display("FAIL zero_hist nonzero_bins=%0d exp=0", bad); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d; logic v; int n, bad;
    logic [15:0] seq [10] = '{16'd5, 16'd5, 16'd5, 16'd5, 16'd7, 16'd5, 16'd7, 16'd5, 16'd7, 16'd5};
    start_pass(24'd10);
    goto_acq();
    for (int i = 0; i < 10; i++) feed(seq[i], 1'b1);
    wait_done(n);
    checks++; if (n !== 3) begin failures++; $display("FAIL b2b_done_latency got=%0d exp=3", n); end
    checks++; if (hits !== 24'd10) begin failures++; $display("FAIL b2b_hits got=%0d exp=10", hits); end
    read_bin(10'd5, d, v);
    checks++; if (v !== 1'b1 || d !== 16'd7) begin failures++; $display("FAIL b2b_bin5 got=%0d valid=%b exp=7", d, v); end
    read_bin(10'd7, d, v);
    checks++; if (v !== 1'b1 || d !== 16'd3) begin failures++; $display("FAIL b2b_bin7 got=%0d valid=%b exp=3", d, v); end
    scan_others(5, 7, -1, bad);
    checks++; if (bad !== 0) begin failures++; $display("FAIL b2b_other_bins nonzero=%0d exp=0", bad); end
  endtask

  task automatic test_code_filter();
    logic [15:0] d; logic v; int n, bad;
    logic [15:0] seq [8] = '{16'd0, 16'd600, 16'd3, 16'd1, 16'd575, 16'd2, 16'd2, 16'd9};
    logic        val [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    start_pass(24'd4);
    goto_acq();
    for (int i = 0; i < 8; i++) feed(seq[i], val[i]);
    wait_done(n);
    checks++; if (n !== 2) begin failures++; $display("FAIL filt_done_latency got=%0d exp=2", n); end
    checks++; if (hits !== 24'd4) begin failures++; $display("FAIL filt_hits got=%0d exp=4", hits); end
    read_bin(10'd1, d, v);
    checks++; if (d !== 16'd1) begin failures++; $display("FAIL filt_bin1 got=%0d exp=1", d); end
    read_bin(10'd575, d, v);
    checks++; if (d !== 16'd1) begin failures++; $display("FAIL filt_bin575 got=%0d exp=1", d); end
    read_bin(10'd9, d, v);
    checks++; if (d !== 16'd0) begin failures++; $display("FAIL filt_bin9 got=%0d exp=0", d); end
    read_bin(10'd3, d, v);
    checks++; if (d !== 16'd0) begin failures++; $display("FAIL filt_bin3 got=%0d exp=0", d); end
    read_bin(10'd2, d, v);
    checks++; if (d !== 16'd2) begin failures++; $display("FAIL filt_bin2 got=%0d exp=2", d); end
    scan_others(1, 2, 575, bad);
    checks++; if (bad !== 0) begin failures++; $display("FAIL filt_other_bins nonzero=%0d exp=0", bad); end
  endtask

  task automatic test_saturation();
    int n;
    start4 = 1'b1;
    num_hits4 = 24'd20;
    tick();
    start4 = 1'b0;
    repeat (16) tick();
    for (int i = 1; i <= 20; i++) begin
      code4 = 16'd12;
      code_valid4 = 1'b1;
      tick();
      if (i == 15) begin
        checks++; if (ovf4 !== 1'b0) begin failures++; $display("FAIL sat_ovf_early got=%b exp=0", ovf4); end
      end
      if (i == 16) begin
        checks++; if (ovf4 !== 1'b1) begin failures++; $display("FAIL sat_ovf_set got=%b exp=1", ovf4); end
      end
    end
    code_valid4 = 1'b0;
    code4 = 16'd0;
    n = 0;
    while (done4 !== 1'b1 && n < 50) begin tick(); n++; end
    checks++; if (n !== 3) begin failures++; $display("FAIL sat_done_latency got=%0d exp=3", n); end
    tick();
    checks++; if (hits4 !== 24'd20) begin failures++; $display("FAIL sat_hits got=%0d exp=20", hits4); end
    rd_en4 = 1'b1;
    rd_addr4 = 4'd12;
    tick();
    rd_en4 = 1'b0;
    checks++; if (rd_valid4 !== 1'b1 || rd_data4 !== 4'd15) begin failures++; $display("FAIL sat_bin12 got=%0d valid=%b exp=15", rd_data4, rd_valid4); end
    repeat (5) tick();
    checks++; if (ovf4 !== 1'b1) begin failures++; $display("FAIL sat_ovf_sticky got=%b exp=1", ovf4); end
    start4 = 1'b1;
    num_hits4 = 24'd0;
    tick();
    start4 = 1'b0;
    checks++; if (ovf4 !== 1'b0) begin failures++; $display("FAIL sat_ovf_cleared got=%b exp=0", ovf4); end
    n = 0;
    while (done4 !== 1'b1 && n < 50) begin tick(); n++; end
    checks++; if (n >= 50) begin failures++; $display("FAIL sat_second_pass_timeout waited=%0d", n); end
    tick();
  endtask

  task automatic test_ignored_requests();
    logic [15:0] d; logic v; int n;
    read_bin(10'd2, d, v);
    start_pass(24'd3);
    goto_acq();
    code = 16'd4; code_valid = 1'b1;
    start = 1'b1; num_hits = 24'd9;
    rd_en = 1'b1; rd_addr = 10'd4;
    tick();
    code_valid = 1'b0; start = 1'b0; rd_en = 1'b0;
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL ign_rd_valid got=%b exp=0", rd_valid); end
    checks++; if (rd_data !== 16'd2) begin failures++; $display("FAIL ign_rd_data_hold got=%0d exp=2", rd_data); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ign_busy got=%b exp=1", busy); end
    feed(16'd4, 1'b1);
    feed(16'd6, 1'b1);
    wait_done(n);
    checks++; if (n !== 3) begin failures++; $display("FAIL ign_done_latency got=%0d exp=3", n); end
    checks++; if (hits !== 24'd3) begin failures++; $display("FAIL ign_hits got=%0d exp=3", hits); end
    read_bin(10'd4, d, v);
    checks++; if (d !== 16'd2) begin failures++; $display("FAIL ign_bin4 got=%0d exp=2", d); end
    read_bin(10'd6, d, v);
    checks++; if (d !== 16'd1) begin failures++; $display("FAIL ign_bin6 got=%0d exp=1", d); end
    read_bin(10'd1000, d, v);
    checks++; if (v !== 1'b1 || d !== 16'd0) begin failures++; $display("FAIL ign_oor_read got=%0d valid=%b exp=0 valid=1", d, v); end
  endtask

  task automatic test_reset_abort();
    logic [15:0] d; logic v; int n, bad;
    start_pass(24'd5);
    goto_acq();
    feed(16'd8, 1'b1);
    feed(16'd8, 1'b1);
    code = 16'd8; code_valid = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; code_valid = 1'b0; code = 16'd0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin failures++; $display("FAIL abort_flags busy=%b done=%b ovf=%b exp=000", busy, done, ovf); end
    checks++; if (hits !== 24'd0) begin failures++; $display("FAIL abort_hits got=%0d exp=0", hits); end
    checks++; if (rd_valid !== 1'b0 || rd_data !== 16'd0) begin failures++; $display("FAIL abort_rd got=%0d valid=%b exp=0 valid=0", rd_data, rd_valid); end
    start_pass(24'd2);
    goto_acq();
    feed(16'd3, 1'b1);
    feed(16'd3, 1'b1);
    wait_done(n);
    checks++; if (n !== 3) begin failures++; $display("FAIL abort_done_latency got=%0d exp=3", n); end
    checks++; if (hits !== 24'd2) begin failures++; $display("FAIL abort_hits_after got=%0d exp=2", hits); end
    read_bin(10'd3, d, v);
    checks++; if (d !== 16'd2) begin failures++; $display("FAIL abort_bin3 got=%0d exp=2", d); end
    scan_others(3, -1, -1, bad);
    checks++; if (bad !== 0) begin failures++; $display("FAIL abort_other_bins nonzero=%0d exp=0", bad); end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; num_hits = '0; code_valid = 1'b0; code = '0;
    rd_en = 1'b0; rd_addr = '0;
    start4 = 1'b0; num_hits4 = '0; code_valid4 = 1'b0; code4 = '0;
    rd_en4 = 1'b0; rd_addr4 = '0;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_zero_hits();
    test_back_to_back();
    test_code_filter();
    test_saturation();
    test_ignored_requests();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
